// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_pkg
//  Description : Shared constants, state encoding and BCD helpers for the
//                time-of-day / alarm stage.
//  Revision    : 1.0
// ============================================================================
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RINGING  = 2'd1,
        ST_SNOOZING = 2'd2
    } alarm_state_t;

    localparam int c_BCD_W       = 4;
    localparam int c_HHMM_W      = 16;
    localparam int c_HHMMSS_W    = 24;
    localparam int c_MAX_DIGIT   = 9;
    localparam int c_MAX_H10     = 2;
    localparam int c_MAX_M10     = 5;
    localparam int c_HOURS_LIMIT = 23;

    function automatic logic hhmm_valid(input logic [c_HHMM_W-1:0] v);
        int h10, h1, m10, m1;
        h10 = int'(v[15:12]);
        h1  = int'(v[11:8]);
        m10 = int'(v[7:4]);
        m1  = int'(v[3:0]);
        return (h10 <= c_MAX_H10) && (h1 <= c_MAX_DIGIT) &&
               (m10 <= c_MAX_M10) && (m1 <= c_MAX_DIGIT) &&
               (h10 * 10 + h1 <= c_HOURS_LIMIT);
    endfunction

    // HH:MM one minute later, wrapping 23:59 to 00:00.
    function automatic logic [c_HHMM_W-1:0] hhmm_inc(input logic [c_HHMM_W-1:0] v);
        logic [3:0] h10, h1, m10, m1;
        h10 = v[15:12];
        h1  = v[11:8];
        m10 = v[7:4];
        m1  = v[3:0];
        if (m1 != 4'(c_MAX_DIGIT)) begin
            m1 = m1 + 4'd1;
        end else begin
            m1 = 4'd0;
            if (m10 != 4'(c_MAX_M10)) begin
                m10 = m10 + 4'd1;
            end else begin
                m10 = 4'd0;
                if (h10 == 4'(c_HOURS_LIMIT / 10) && h1 == 4'(c_HOURS_LIMIT % 10)) begin
                    h10 = 4'd0;
                    h1  = 4'd0;
                end else if (h1 == 4'(c_MAX_DIGIT)) begin
                    h1  = 4'd0;
                    h10 = h10 + 4'd1;
                end else begin
                    h1 = h1 + 4'd1;
                end
            end
        end
        return {h10, h1, m10, m1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_counter
//  Description : Single BCD digit, counts 0..MAX_VAL with carry-out and load.
//  Revision    : 1.0
// ============================================================================
module bcd_digit_counter
    import alarm_pkg::*;
#(
    parameter int MAX_VAL = 9
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               load,
    input  logic [c_BCD_W-1:0] load_value,
    output logic [c_BCD_W-1:0] digit,
    output logic               carry_out
);

    logic [c_BCD_W-1:0] r_digit;

    assign digit     = r_digit;
    assign carry_out = enable && (r_digit == c_BCD_W'(MAX_VAL));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_digit <= '0;
        end else if (load) begin
            r_digit <= load_value;
        end else if (enable) begin
            r_digit <= carry_out ? '0 : r_digit + c_BCD_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/time_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : time_keeper
//  Description : 24 h BCD time-of-day counter with load and ring/snooze alarm.
//  Revision    : 1.0
// ============================================================================
module time_keeper
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  one_second,
    input  logic                  load_time,
    input  logic [c_HHMM_W-1:0]   load_hhmm,
    input  logic [c_HHMM_W-1:0]   alarm_hhmm,
    input  logic                  alarm_enable,
    input  logic                  snooze,
    input  logic                  stop,
    output logic [c_HHMMSS_W-1:0] time_hhmmss,
    output logic                  minute_tick,
    output logic                  load_error,
    output logic                  alarm_ring,
    output logic [1:0]            alarm_state
);

    localparam logic [7:0] c_RING_LOAD = 8'(RING_TIMEOUT_S);
    localparam logic [3:0] c_SNZ_LOAD  = 4'(SNOOZE_MIN);

    logic                 w_tick;
    logic                 w_load_ok;
    logic                 w_load_bad;
    logic                 w_min_wrap;
    logic                 w_match;
    logic [3:0]           w_en;
    logic [3:0]           w_carry;
    logic [c_BCD_W-1:0]   w_digit    [4];
    logic [c_BCD_W-1:0]   w_ld_digit [4];
    logic [c_HHMM_W-1:0]  w_hhmm;

    logic [3:0]           r_h10;
    logic [3:0]           r_h1;
    logic                 r_minute_tick;
    logic                 r_load_error;
    alarm_state_t         r_state;
    logic                 r_alarm_ring;
    logic [7:0]           r_ring_cnt;
    logic [3:0]           r_snz_cnt;

    // A load, valid or not, swallows a coincident strobe.
    assign w_tick     = one_second && !load_time;
    assign w_load_ok  = load_time && hhmm_valid(load_hhmm);
    assign w_load_bad = load_time && !hhmm_valid(load_hhmm);

    assign w_ld_digit[0] = '0;
    assign w_ld_digit[1] = '0;
    assign w_ld_digit[2] = load_hhmm[3:0];
    assign w_ld_digit[3] = load_hhmm[7:4];

    // Digit order: S1, S10, M1, M10.
    generate
        for (genvar i = 0; i < 4; i++) begin : g_digit
            if (i == 0) begin : g_first
                assign w_en[i] = w_tick;
            end else begin : g_chain
                assign w_en[i] = w_carry[i-1];
            end
            bcd_digit_counter #(
                .MAX_VAL((i % 2 == 1) ? c_MAX_M10 : c_MAX_DIGIT)
            ) u_digit (
                .clock      (clock),
                .reset      (reset),
                .enable     (w_en[i]),
                .load       (w_load_ok),
                .load_value (w_ld_digit[i]),
                .digit      (w_digit[i]),
                .carry_out  (w_carry[i])
            );
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_h10 <= '0;
            r_h1  <= '0;
        end else if (w_load_ok) begin
            r_h10 <= load_hhmm[15:12];
            r_h1  <= load_hhmm[11:8];
        end else if (w_carry[3]) begin
            if (r_h10 == 4'(c_HOURS_LIMIT / 10) && r_h1 == 4'(c_HOURS_LIMIT % 10)) begin
                r_h10 <= '0;
                r_h1  <= '0;
            end else if (r_h1 == 4'(c_MAX_DIGIT)) begin
                r_h10 <= r_h10 + 4'd1;
                r_h1  <= '0;
            end else begin
                r_h1 <= r_h1 + 4'd1;
            end
        end
    end

    assign w_min_wrap = w_carry[1];
    assign w_hhmm     = {r_h10, r_h1, w_digit[3], w_digit[2]};
    // Compare against the minute being entered so the ring lines up with minute_tick.
    assign w_match    = (hhmm_inc(w_hhmm) == alarm_hhmm);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_minute_tick <= 1'b0;
            r_load_error  <= 1'b0;
        end else begin
            r_minute_tick <= w_min_wrap;
            r_load_error  <= w_load_bad;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_alarm_ring <= 1'b0;
            r_ring_cnt   <= '0;
            r_snz_cnt    <= '0;
        end else if (!alarm_enable) begin
            r_state      <= ST_IDLE;
            r_alarm_ring <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_min_wrap && w_match) begin
                        r_state      <= ST_RINGING;
                        r_alarm_ring <= 1'b1;
                        r_ring_cnt   <= c_RING_LOAD;
                    end
                end
                ST_RINGING: begin
                    if (stop) begin
                        r_state      <= ST_IDLE;
                        r_alarm_ring <= 1'b0;
                    end else if (snooze) begin
                        r_state      <= ST_SNOOZING;
                        r_alarm_ring <= 1'b0;
                        r_snz_cnt    <= c_SNZ_LOAD;
                    end else if (one_second) begin
                        r_ring_cnt <= r_ring_cnt - 8'd1;
                        if (r_ring_cnt == 8'd1) begin
                            r_state      <= ST_IDLE;
                            r_alarm_ring <= 1'b0;
                        end
                    end
                end
                ST_SNOOZING: begin
                    if (stop) begin
                        r_state      <= ST_IDLE;
                        r_alarm_ring <= 1'b0;
                    end else if (w_min_wrap) begin
                        r_snz_cnt <= r_snz_cnt - 4'd1;
                        if (r_snz_cnt == 4'd1) begin
                            r_state      <= ST_RINGING;
                            r_alarm_ring <= 1'b1;
                            r_ring_cnt   <= c_RING_LOAD;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_alarm_ring <= 1'b0;
                end
            endcase
        end
    end

    assign time_hhmmss = {r_h10, r_h1, w_digit[3], w_digit[2], w_digit[1], w_digit[0]};
    assign minute_tick = r_minute_tick;
    assign load_error  = r_load_error;
    assign alarm_ring  = r_alarm_ring;
    assign alarm_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_time_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_keeper
//  Description : Self-checking bench for time_keeper against a seconds-of-day model.
//  Revision    : 1.0
// ============================================================================
module tb_time_keeper;

    localparam int SNOOZE_MIN     = 5;
    localparam int RING_TIMEOUT_S = 60;

    logic        clock        = 1'b0;
    logic        reset        = 1'b1;
    logic        one_second   = 1'b0;
    logic        load_time    = 1'b0;
    logic [15:0] load_hhmm    = '0;
    logic [15:0] alarm_hhmm   = '0;
    logic        alarm_enable = 1'b0;
    logic        snooze       = 1'b0;
    logic        stop         = 1'b0;
    logic [23:0] time_hhmmss;
    logic        minute_tick;
    logic        load_error;
    logic        alarm_ring;
    logic [1:0]  alarm_state;

    time_keeper #(
        .SNOOZE_MIN     (SNOOZE_MIN),
        .RING_TIMEOUT_S (RING_TIMEOUT_S)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .one_second   (one_second),
        .load_time    (load_time),
        .load_hhmm    (load_hhmm),
        .alarm_hhmm   (alarm_hhmm),
        .alarm_enable (alarm_enable),
        .snooze       (snooze),
        .stop         (stop),
        .time_hhmmss  (time_hhmmss),
        .minute_tick  (minute_tick),
        .load_error   (load_error),
        .alarm_ring   (alarm_ring),
        .alarm_state  (alarm_state)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: time as seconds since midnight, alarm as 0 idle / 1 ringing / 2 snoozing.
    int   m_secs = 0;
    int   m_st   = 0;
    int   m_ring = 0;
    int   m_snz  = 0;
    logic m_mt   = 1'b0;
    logic m_le   = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [23:0] to_bcd(int s);
        int h, m, sc;
        h  = s / 3600;
        m  = (s / 60) % 60;
        sc = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic logic [15:0] mins_to_hhmm(int mins);
        logic [23:0] b;
        b = to_bcd(mins * 60);
        return b[23:8];
    endfunction

    function automatic void model_reset();
        m_secs = 0; m_st = 0; m_ring = 0; m_snz = 0; m_mt = 1'b0; m_le = 1'b0;
    endfunction

    function automatic void model_update();
        int h10, h1, m10, m1;
        logic [23:0] b;
        m_mt = 1'b0;
        m_le = 1'b0;
        if (load_time) begin
            h10 = int'(load_hhmm[15:12]); h1 = int'(load_hhmm[11:8]);
            m10 = int'(load_hhmm[7:4]);   m1 = int'(load_hhmm[3:0]);
            if (h10 <= 2 && h1 <= 9 && m10 <= 5 && m1 <= 9 && h10 * 10 + h1 <= 23)
                m_secs = (h10 * 10 + h1) * 3600 + (m10 * 10 + m1) * 60;
            else
                m_le = 1'b1;
        end else if (one_second) begin
            m_secs = (m_secs + 1) % 86400;
            m_mt   = (m_secs % 60 == 0);
        end
        b = to_bcd(m_secs);
        if (!alarm_enable) begin
            m_st = 0;
        end else if (m_st == 0) begin
            if (m_mt && b[23:8] == alarm_hhmm) begin
                m_st = 1; m_ring = RING_TIMEOUT_S;
            end
        end else if (m_st == 1) begin
            if (stop) m_st = 0;
            else if (snooze) begin m_st = 2; m_snz = SNOOZE_MIN; end
            else if (one_second) begin
                m_ring--;
                if (m_ring == 0) m_st = 0;
            end
        end else begin
            if (stop) m_st = 0;
            else if (m_mt) begin
                m_snz--;
                if (m_snz == 0) begin m_st = 1; m_ring = RING_TIMEOUT_S; end
            end
        end
    endfunction

    always @(negedge clock) begin
        check("time", 32'(time_hhmmss), 32'(to_bcd(m_secs)));
        check("minute_tick", 32'(minute_tick), 32'(m_mt));
        check("load_error", 32'(load_error), 32'(m_le));
        check("alarm_ring", 32'(alarm_ring), 32'(m_st == 1));
        check("alarm_state", 32'(alarm_state), 32'(m_st));
    end

    task automatic step(input logic ld, input logic [15:0] lv, input logic os,
                        input logic sz, input logic sp);
        load_time = ld; load_hhmm = lv; one_second = os; snooze = sz; stop = sp;
        @(posedge clock);
        if (!reset) model_update();
        #1;
        load_time = 1'b0; one_second = 1'b0; snooze = 1'b0; stop = 1'b0;
    endtask

    task automatic strobes(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_reset_time", 32'(time_hhmmss), 32'h0);
        check("async_reset_ring", 32'(alarm_ring), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic ring_at_0700();
        step(1'b1, 16'h0659, 1'b0, 1'b0, 1'b0);
        strobes(60);
        check("ring_at_0700", 32'(alarm_ring), 32'h1);
    endtask

    initial begin
        logic [15:0] pre;
        int amins;

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_time", 32'(time_hhmmss), 32'h0);
        check("reset_state", 32'(alarm_state), 32'h0);

        // Reset in the middle of counting.
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        strobes(56);
        check("time_123456", 32'(time_hhmmss), 32'h123456);
        do_reset();
        check("post_reset_time", 32'(time_hhmmss), 32'h0);

        // Day wrap.
        step(1'b1, 16'h2359, 1'b0, 1'b0, 1'b0);
        strobes(1);
        check("time_235901", 32'(time_hhmmss), 32'h235901);
        strobes(58);
        check("no_tick_235959", 32'(minute_tick), 32'h0);
        strobes(1);
        check("wrap_000000", 32'(time_hhmmss), 32'h000000);
        check("wrap_tick", 32'(minute_tick), 32'h1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("tick_one_cycle", 32'(minute_tick), 32'h0);

        // Rejected loads and load-over-strobe priority.
        step(1'b1, 16'h2460, 1'b0, 1'b0, 1'b0);
        check("bad_2460_err", 32'(load_error), 32'h1);
        check("bad_2460_time", 32'(time_hhmmss), 32'h000000);
        step(1'b1, 16'h1960, 1'b0, 1'b0, 1'b0);
        check("bad_1960_err", 32'(load_error), 32'h1);
        step(1'b1, 16'h0815, 1'b1, 1'b0, 1'b0);
        check("load_0815", 32'(time_hhmmss), 32'h081500);
        check("load_no_err", 32'(load_error), 32'h0);

        // Alarm ring and unattended timeout.
        alarm_hhmm   = 16'h0700;
        alarm_enable = 1'b1;
        ring_at_0700();
        check("ring_tick", 32'(minute_tick), 32'h1);
        check("ring_state", 32'(alarm_state), 32'h1);
        strobes(59);
        check("still_ringing_59", 32'(alarm_state), 32'h1);
        strobes(1);
        check("timeout_idle", 32'(alarm_state), 32'h0);

        // Snooze then re-ring at 07:05:00, then stop.
        ring_at_0700();
        strobes(10);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        check("snoozing", 32'(alarm_state), 32'h2);
        strobes(289);
        check("snooze_0704_59", 32'(alarm_state), 32'h2);
        strobes(1);
        check("rering_time", 32'(time_hhmmss), 32'h070500);
        check("rering", 32'(alarm_ring), 32'h1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        check("stop_idle", 32'(alarm_state), 32'h0);

        // Stop and snooze together, then enable dropped while snoozing.
        ring_at_0700();
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        check("stop_beats_snooze", 32'(alarm_state), 32'h0);
        ring_at_0700();
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        alarm_enable = 1'b0;
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        check("disable_idle", 32'(alarm_state), 32'h0);
        strobes(300);
        check("no_rering", 32'(alarm_ring), 32'h0);
        alarm_enable = 1'b1;

        // Reset while ringing.
        ring_at_0700();
        do_reset();
        check("reset_mid_ring", 32'(alarm_state), 32'h0);

        // Randomized traffic around a random alarm time.
        for (int blk = 0; blk < 4; blk++) begin
            amins      = int'($urandom_range(0, 1439));
            alarm_hhmm = mins_to_hhmm(amins);
            pre        = mins_to_hhmm((amins + 1439) % 1440);
            step(1'b1, pre, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 1500; c++) begin
                alarm_enable = ($urandom_range(0, 299) != 0);
                step($urandom_range(0, 399) == 0,
                     ($urandom_range(0, 1) == 1) ? pre : 16'($urandom),
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 149) == 0,
                     $urandom_range(0, 299) == 0);
            end
        end

        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Time-of-day and alarm stage that sits directly downstream of the 1 Hz timing generator.
- Consumes its single-cycle one_second strobe and keeps a BCD HH:MM:SS time-of-day counter (24 h).
- Supports synchronous time loading and compares the time against an alarm setting.
- Runs a small alarm FSM (ring / snooze / stop / timeout) that drives the alarm output to the display/buzzer stage.

Parameters:
- SNOOZE_MIN, 5, minutes spent in snooze before re-ringing (1..9).
- RING_TIMEOUT_S, 60, seconds the alarm rings unattended before auto-stop (1..255).

Ports:
- clock  in  1  system clock; every register updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- one_second  in  1  single-cycle strobe, synchronous to clock, 1 per second.
- load_time  in  1  level sampled each cycle; load load_hhmm into the time counter.
- load_hhmm  in  16  BCD {H10,H1,M10,M1}.
- alarm_hhmm  in  16  BCD alarm time {H10,H1,M10,M1}; held stable by the user-interface stage.
- alarm_enable  in  1  arms the alarm.
- snooze  in  1  single-cycle request.
- stop  in  1  single-cycle request.
- time_hhmmss  out  24  BCD {H10,H1,M10,M1,S10,S1}.
- minute_tick  out  1  1-cycle pulse on the seconds 59->00 wrap.
- load_error  out  1  1-cycle pulse when a load is rejected.
- alarm_ring  out  1  high while in the RINGING state.
- alarm_state  out  2  current FSM state encoding.

Behaviour:
Reset and strobe handling:
- Reset (asynchronous, active-high, any time including mid-ring): time = 00:00:00, all outputs 0, FSM = IDLE, snooze and ring counters = 0.
- All other updates are synchronous to the rising edge of clock.
- one_second is counted only on clock edges where it is high. It is assumed to be a 1-cycle strobe; a level held for N cycles counts N times.

Time counter:
- S1 counts 0..9, S10 0..5, M1 0..9, M10 0..5; hours count 00..23 and wrap to 00.
- Each digit carries into the next on wrap. Every digit is always valid BCD.
- The 23:59:59 + tick step yields 00:00:00 and asserts minute_tick.
- minute_tick asserts in the same cycle the registers show SS=00 as a result of a tick.
- Latency: the time_hhmmss change is visible the cycle after the one_second strobe (registered output).

Load:
- load_time has priority over one_second in the same cycle: time <= load_hhmm:00 and the tick is dropped.
- Validation: each digit must be ≤9, H10 ≤2, HH ≤23 and M10 ≤5. An invalid value leaves the time unchanged and pulses load_error for 1 cycle.
- A load never generates minute_tick and never triggers the alarm.

Alarm FSM (alarm_state encoding: IDLE=0, RINGING=1, SNOOZING=2):
- IDLE -> RINGING: in the cycle minute_tick asserts with alarm_enable=1 and the new HH:MM == alarm_hhmm. The ring counter loads RING_TIMEOUT_S.
- RINGING:
  - The ring counter decrements on each one_second strobe.
  - stop -> IDLE.
  - snooze -> SNOOZING, with the snooze counter loaded to SNOOZE_MIN.
  - Ring counter reaching 0 -> IDLE.
- SNOOZING:
  - The snooze counter decrements on each minute_tick.
  - On reaching 0 -> RINGING (ring counter reloaded).
  - stop -> IDLE.
  - snooze is ignored.
- alarm_enable=0 forces IDLE from any state on the next edge.
- Priority when events coincide: reset > alarm_enable low > stop > snooze > timeout/expiry > match.
- A match while already RINGING or SNOOZING is ignored.
- alarm_ring is registered and equals (state==RINGING).

Decomposition:
- Shared package alarm_pkg:
  - state encoding constants (IDLE/RINGING/SNOOZING);
  - BCD digit width constant (4);
  - HHMM and HHMMSS field widths and digit limits (MAX_H10=2, MAX_M10=5);
  - the 24 h hours-limit constant.
- One natural sub-module: bcd_digit_counter. It is a single BCD digit with an enable input, a parameterised max value, and carry-out and synchronous-load inputs. It is instanced for S1/S10/M1/M10. Hours use a custom 00..23 pair in the parent.
- The alarm FSM stays inline in time_keeper.

Test Plan:
- Reset mid-count at 12:34:56 -> next cycle time_hhmmss=000000, alarm_ring=0, alarm_state=0.
- load_hhmm=2359 then 1 one_second strobe -> 23:59:01; 59 more strobes -> 00:00:00 with minute_tick=1 for exactly 1 cycle.
- load_hhmm=2460, then 1960 -> time unchanged and load_error pulsed for each; load_time and one_second in the same cycle with 0815 -> 08:15:00, tick dropped.
- alarm_hhmm=0700, alarm_enable=1, load 0659, 60 strobes -> alarm_ring=1 in the minute_tick cycle; 60 more strobes with no stop -> IDLE and alarm_ring=0.
- Ringing at 07:00, snooze at 07:00:10 -> SNOOZING; alarm_ring=1 again in the 07:05:00 tick cycle (SNOOZE_MIN=5); stop -> IDLE.
- Same-cycle stop+snooze while RINGING -> IDLE. alarm_enable dropped in SNOOZING -> IDLE, and no re-ring at 07:05.
